// File: rtl/cordic_job_ctrl.sv
// Job sequencer in front of the CORDIC core: accepts one request at a time,
// folds circular-rotation angles into the core's convergence range, and drives
// the core with a settle window before start.
// After the core finishes, it applies the quadrant sign fix and returns the
// result through a valid/ready port. A timeout guards against a core that
// never raises done.
module cordic_job_ctrl #(
  parameter int              DW      = 64,
  parameter int              IW      = 6,
  parameter int              SETTLE  = 2,
  parameter int              TIMEOUT = 96,
  parameter logic [DW-1:0]   HALF_PI = 64'h6487ED5110B4611A,
  parameter logic [DW-1:0]   PI      = 64'hC90FDAA22168C235
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_z,
  input  logic [DW-1:0] req_x,
  input  logic [DW-1:0] req_y,
  input  logic [IW-1:0] req_iters,
  output logic          calc_start,
  output logic [2:0]    calc_mode,
  output logic [DW-1:0] calc_z,
  output logic [DW-1:0] calc_xx,
  output logic [DW-1:0] calc_yy,
  output logic [IW-1:0] calc_dur,
  input  logic [DW-1:0] calc_xo,
  input  logic [DW-1:0] calc_yo,
  input  logic [DW-1:0] calc_zo,
  input  logic          calc_done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_x,
  output logic [DW-1:0] res_y,
  output logic [DW-1:0] res_z,
  output logic          res_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_OUT} state_t;

  localparam int CW = $clog2(TIMEOUT + SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  // Angles are compared and adjusted one bit wider so the +/-PI step cannot
  // overflow before the result is known to fit back into DW bits.
  localparam logic signed [DW:0] HALF_PI_E = {1'b0, HALF_PI};
  localparam logic signed [DW:0] PI_E      = {1'b0, PI};

  state_t        state;
  logic [CW-1:0] cnt;
  logic          flip;
  logic          op_bad;

  logic signed [DW:0] z_ext;
  logic [DW-1:0]      z_fold;
  logic               fold_flip;
  logic               op_legal;

  // The controller is only open for a new job while idle and out of reset.
  assign req_ready = rst_n && (state == ST_IDLE);

  // Decode the op and fold circular-rotation angles beyond +/-pi/2 by one
  // half turn; the result sign is corrected after the core run.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise an unassigned path infers a latch.
    z_ext     = {req_z[DW-1], req_z};
    z_fold    = req_z;
    fold_flip = 1'b0;
    op_legal  = (req_op == 3'b000) || (req_op == 3'b001) ||
                (req_op == 3'b100) || (req_op == 3'b101);
    if (req_op == 3'b000) begin
      if (z_ext > HALF_PI_E) begin
        z_fold    = DW'(z_ext - PI_E);
        fold_flip = 1'b1;
      end else if (z_ext < -HALF_PI_E) begin
        z_fold    = DW'(z_ext + PI_E);
        fold_flip = 1'b1;
      end
    end
  end

  // Job sequencer: accept, settle operands, run the core, hold the result.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, so it belongs inside the
    // clocked block rather than in the sensitivity list.
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      flip       <= 1'b0;
      op_bad     <= 1'b0;
      calc_start <= 1'b0;
      calc_mode  <= '0;
      calc_z     <= '0;
      calc_xx    <= '0;
      calc_yy    <= '0;
      calc_dur   <= '0;
      res_valid  <= 1'b0;
      res_err    <= 1'b0;
      res_x      <= '0;
      res_y      <= '0;
      res_z      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // sees the pre-edge values regardless of statement order.
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            calc_mode <= req_op;
            calc_z    <= z_fold;
            calc_xx   <= req_x;
            calc_yy   <= req_y;
            calc_dur  <= req_iters;
            flip      <= fold_flip;
            op_bad    <= !op_legal;
            cnt       <= '0;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (op_bad) begin
            // Illegal op: the core is never started.
            res_x     <= '0;
            res_y     <= '0;
            res_z     <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= ST_OUT;
          end else if (cnt == SETTLE_LAST) begin
            cnt        <= '0;
            calc_start <= 1'b1;
            state      <= ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (calc_done) begin
            res_x      <= flip ? -calc_xo : calc_xo;
            res_y      <= flip ? -calc_yo : calc_yo;
            res_z      <= calc_zo;
            res_err    <= 1'b0;
            res_valid  <= 1'b1;
            calc_start <= 1'b0;
            state      <= ST_OUT;
          end else if (cnt == TIMEOUT_LAST) begin
            res_x      <= '0;
            res_y      <= '0;
            res_z      <= '0;
            res_err    <= 1'b1;
            res_valid  <= 1'b1;
            calc_start <= 1'b0;
            state      <= ST_OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_job_ctrl.sv
// Scoreboard bench for cordic_job_ctrl. A behavioural core model answers
// circular rotation with real cos/sin of the angle it was given, and echoes
// operands for the other modes. Expected results are queued at accept time
// and checked by an independent monitor when res_valid appears.
module tb_cordic_job_ctrl;

  localparam int          SETTLE  = 2;
  localparam int          TIMEOUT = 96;
  localparam logic [63:0] HALF_PI = 64'h6487ED5110B4611A;
  localparam logic [63:0] PI      = 64'hC90FDAA22168C235;
  localparam real         ONE     = 4611686018427387904.0;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_z, req_x, req_y;
  logic [5:0]  req_iters;
  logic        calc_start;
  logic [2:0]  calc_mode;
  logic [63:0] calc_z, calc_xx, calc_yy;
  logic [5:0]  calc_dur;
  logic [63:0] calc_xo, calc_yo, calc_zo;
  logic        calc_done;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_x, res_y, res_z;
  logic        res_err;

  cordic_job_ctrl #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_z(req_z), .req_x(req_x), .req_y(req_y), .req_iters(req_iters),
    .calc_start(calc_start), .calc_mode(calc_mode), .calc_z(calc_z),
    .calc_xx(calc_xx), .calc_yy(calc_yy), .calc_dur(calc_dur),
    .calc_xo(calc_xo), .calc_yo(calc_yo), .calc_zo(calc_zo), .calc_done(calc_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] to_fix(input real r);
    longint v;
    v = longint'(r * ONE);
    return v;
  endfunction

  function automatic real to_real(input logic [63:0] v);
    longint s;
    real    r;
    s = v;
    r = s;
    return r / ONE;
  endfunction

  // Core model: done arrives iters+3 cycles after start rises.
  bit core_dead = 1'b0;
  int core_cnt  = 0;
  initial begin
    calc_done = 1'b0;
    calc_xo   = '0;
    calc_yo   = '0;
    calc_zo   = '0;
  end
  always @(posedge clk) begin
    if (!calc_start) begin
      core_cnt = 0;
      calc_done <= 1'b0;
    end else if (!calc_done && !core_dead) begin
      core_cnt++;
      if (core_cnt == int'(calc_dur) + 3) begin
        calc_done <= 1'b1;
        calc_zo   <= calc_z;
        if (calc_mode == 3'b000) begin
          calc_xo <= to_fix($cos(to_real(calc_z)));
          calc_yo <= to_fix($sin(to_real(calc_z)));
        end else begin
          calc_xo <= calc_xx;
          calc_yo <= calc_yy;
        end
      end
    end
  end

  typedef struct {
    bit          approx;
    real         ex;
    real         ey;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] z;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_real(input string name, input real got, input real want);
    real d;
    n_cmp++;
    d = got - want;
    if (d < 0.0) d = -d;
    if (d > 1.0e-9) begin
      n_bad++;
      $display("FAIL %s: got %0.12f, want %0.12f (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk_rot(input real ex, input real ey, input logic [63:0] z, input int lat);
    exp_t e;
    e.approx = 1'b1; e.ex = ex; e.ey = ey;
    e.x = '0; e.y = '0; e.z = z; e.err = 1'b0; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  function automatic exp_t mk_exact(input logic [63:0] x, input logic [63:0] y,
                                    input logic [63:0] z, input logic err, input int lat);
    exp_t e;
    e.approx = 1'b0; e.ex = 0.0; e.ey = 0.0;
    e.x = x; e.y = y; e.z = z; e.err = err; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  // Monitor: pops one expectation per result and rechecks it every held cycle.
  exp_t cur;
  bit   taken    = 1'b0;
  int   hand_cyc = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      taken = 1'b0;
    end else if (res_valid) begin
      if (!taken) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: res_valid=1 with no job pending (t=%0t)", $time);
        end else begin
          cur   = sbq.pop_front();
          taken = 1'b1;
          check("latency", 64'(cyc + 1 - cur.acc), 64'(cur.lat));
        end
      end
      if (taken) begin
        if (cur.approx) begin
          check_real("res_x", to_real(res_x), cur.ex);
          check_real("res_y", to_real(res_y), cur.ey);
        end else begin
          check("res_x", res_x, cur.x);
          check("res_y", res_y, cur.y);
        end
        check("res_z", res_z, cur.z);
        check("res_err", 64'(res_err), 64'(cur.err));
        check("req_ready_in_out", 64'(req_ready), 64'd0);
        check("calc_start_in_out", 64'(calc_start), 64'd0);
      end
      if (res_ready) begin
        taken    = 1'b0;
        hand_cyc = cyc + 1;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [63:0] z, input logic [63:0] x,
                      input logic [63:0] y, input logic [5:0] iters, input exp_t e,
                      output int acc);
    int low;
    @(posedge clk);
    #1;
    req_op = op; req_z = z; req_x = x; req_y = y; req_iters = iters;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready never seen for op %b", op);
      req_valid = 1'b0;
      return;
    end
    e.acc = acc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101) begin
      low = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (calc_start) break;
        low++;
      end
      check("settle_low_cycles", 64'(low), 64'(SETTLE));
    end else begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("illegal_no_start", 64'(calc_start), 64'd0);
      end
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !taken && !res_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still outstanding", sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] z05, z18, zn18;
    int          acc, acc2;
    bit          saw_valid;

    z05  = to_fix(0.5);
    z18  = to_fix(1.8);
    zn18 = to_fix(-1.8);
    rst_n = 1'b0; res_ready = 1'b1; req_valid = 1'b0;
    req_op = '0; req_z = '0; req_x = '0; req_y = '0; req_iters = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_calc_start", 64'(calc_start), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    check("rst_res_x", res_x, 64'd0);
    check("rst_calc_z", calc_z, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Rotation, no fold; folds on both sides; exact +/-pi/2 boundaries
    send(3'b000, z05, '0, '0, 6'd40,
         mk_rot(0.8775825618903728, 0.4794255386042030, z05, SETTLE + 45), acc);
    wait_idle();
    send(3'b000, z18, '0, '0, 6'd40,
         mk_rot(-0.2272020946930871, 0.9738476308781951, z18 - PI, SETTLE + 45), acc);
    wait_idle();
    send(3'b000, zn18, '0, '0, 6'd40,
         mk_rot(-0.2272020946930871, -0.9738476308781951, zn18 + PI, SETTLE + 45), acc);
    wait_idle();
    send(3'b000, HALF_PI, '0, '0, 6'd40, mk_rot(0.0, 1.0, HALF_PI, SETTLE + 45), acc);
    wait_idle();
    send(3'b000, -HALF_PI, '0, '0, 6'd40, mk_rot(0.0, -1.0, -HALF_PI, SETTLE + 45), acc);
    wait_idle();

    // Vectoring: operands reach the core unmodified, no sign flip
    send(3'b100, 64'hE000_0000_0000_0001, 64'h3000_0000_0000_0000, 64'hF123_4567_89AB_CDEF, 6'd10,
         mk_exact(64'h3000_0000_0000_0000, 64'hF123_4567_89AB_CDEF, 64'hE000_0000_0000_0001,
                  1'b0, SETTLE + 15), acc);
    wait_idle();

    // Backpressure for 20 cycles with a second job waiting behind it
    res_ready = 1'b0;
    send(3'b000, z05, '0, '0, 6'd20,
         mk_rot(0.8775825618903728, 0.4794255386042030, z05, SETTLE + 25), acc);
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (res_valid) break;
        end
        repeat (20) @(posedge clk);
        #1 res_ready = 1'b1;
      end
      send(3'b101, 64'h0000_0000_0000_00AA, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
           6'd5, mk_exact(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                          64'h0000_0000_0000_00AA, 1'b0, SETTLE + 10), acc2);
    join
    check("b2b_accept_cycle", 64'(acc2), 64'(hand_cyc + 1));
    wait_idle();

    // Timeout: core never answers
    core_dead = 1'b1;
    send(3'b001, z05, '0, '0, 6'd40, mk_exact('0, '0, '0, 1'b1, SETTLE + TIMEOUT + 1), acc);
    wait_idle();
    core_dead = 1'b0;

    // Illegal ops go straight to an error result
    send(3'b011, z05, 64'd7, 64'd9, 6'd40, mk_exact('0, '0, '0, 1'b1, 2), acc);
    wait_idle();
    send(3'b110, z05, 64'd7, 64'd9, 6'd40, mk_exact('0, '0, '0, 1'b1, 2), acc);
    wait_idle();

    // Reset mid-RUN discards the job
    send(3'b000, z05, '0, '0, 6'd40,
         mk_rot(0.8775825618903728, 0.4794255386042030, z05, SETTLE + 45), acc);
    repeat (5) @(posedge clk);
    void'(sbq.pop_back());
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_run_calc_start", 64'(calc_start), 64'd0);
    check("rst_run_idle", 64'(req_ready), 64'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1'b1;
    end
    check("rst_run_no_result", 64'(saw_valid), 64'd0);
    send(3'b000, z18, '0, '0, 6'd30,
         mk_rot(-0.2272020946930871, 0.9738476308781951, z18 - PI, SETTLE + 35), acc);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
